// File: rtl/motion_ramp_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motion_ramp_controller_if                                                  |
// | Command strobe in, conditioned drive request out (toward motor_driver).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface motion_ramp_controller_if;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [31:0] target_duty;
  logic [2:0]  motor_out;
  logic [31:0] period;
  logic [31:0] duty_cycle;
  logic        busy;
  logic        at_speed;

  modport master (
    output cmd, cmd_valid, target_duty,
    input  motor_out, period, duty_cycle, busy, at_speed
  );

  modport slave (
    input  cmd, cmd_valid, target_duty,
    output motor_out, period, duty_cycle, busy, at_speed
  );
endinterface
`default_nettype wire

// File: rtl/motion_ramp_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motion_ramp_controller                                                     |
// | Slews duty toward the commanded target; reversals brake, dwell, then go.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module motion_ramp_controller #(
  parameter int unsigned PERIOD     = 1000,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned STEP       = 10,
  parameter int unsigned DEAD_TICKS = 50
) (
  input  logic                           clk,
  input  logic                           rst_n,
  motion_ramp_controller_if.slave        bus
);

  localparam logic [1:0]  S_STOPPED   = 2'd0;
  localparam logic [1:0]  S_DRIVE     = 2'd1;
  localparam logic [1:0]  S_BRAKE     = 2'd2;
  localparam logic [1:0]  S_DEAD      = 2'd3;

  localparam logic [2:0]  C_CMD_STOP  = 3'd4;
  localparam logic [31:0] C_PERIOD    = 32'(PERIOD);
  localparam logic [31:0] C_STEP      = 32'(STEP);
  localparam logic [31:0] C_TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] C_DEAD      = 32'(DEAD_TICKS);

  logic [2:0]  r_p_cmd;
  logic [31:0] r_p_tgt;
  logic [31:0] r_presc;
  logic [1:0]  r_state;
  logic [2:0]  r_cur_dir;
  logic [31:0] r_duty;
  logic [31:0] r_dead_cnt;
  logic [2:0]  r_motor_out;
  logic        r_busy;
  logic        r_at_speed;

  logic        w_tick;
  logic [2:0]  w_cmd_norm;
  logic [31:0] w_tgt_clamp;
  logic        w_dir_cmd;
  logic [32:0] w_duty_up;
  logic [32:0] w_tgt_up;
  logic [31:0] w_slew;
  logic [31:0] w_brake;

  logic [1:0]  w_state_nxt;
  logic [2:0]  w_dir_nxt;
  logic [31:0] w_duty_nxt;
  logic [31:0] w_dead_nxt;
  logic [2:0]  w_motor_nxt;
  logic        w_busy_nxt;
  logic        w_at_speed_nxt;

  // ---------------------------------------------------------------------------
  // Pending command: latest strobe wins, invalid codes collapse to stop.
  // ---------------------------------------------------------------------------
  assign w_cmd_norm  = (bus.cmd > C_CMD_STOP) ? C_CMD_STOP : bus.cmd;
  assign w_tgt_clamp = (bus.target_duty > C_PERIOD) ? C_PERIOD : bus.target_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_cmd <= C_CMD_STOP;
      r_p_tgt <= '0;
    end else if (bus.cmd_valid) begin
      r_p_cmd <= w_cmd_norm;
      r_p_tgt <= w_tgt_clamp;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running ramp tick prescaler.
  // ---------------------------------------------------------------------------
  assign w_tick = (r_presc == C_TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Slew arithmetic. The upward sum is one bit wider so a large STEP near the
  // top of the range cannot wrap past the target.
  // ---------------------------------------------------------------------------
  assign w_dir_cmd = (r_p_cmd != C_CMD_STOP);
  assign w_duty_up = {1'b0, r_duty} + {1'b0, C_STEP};
  assign w_tgt_up  = {1'b0, r_p_tgt} + {1'b0, C_STEP};
  assign w_brake   = (r_duty > C_STEP) ? (r_duty - C_STEP) : '0;

  always_comb begin
    w_slew = r_p_tgt;
    if (r_duty < r_p_tgt) begin
      w_slew = (w_duty_up > {1'b0, r_p_tgt}) ? r_p_tgt : w_duty_up[31:0];
    end else if (w_tgt_up < {1'b0, r_duty}) begin
      w_slew = r_duty - C_STEP;
    end
  end

  // ---------------------------------------------------------------------------
  // State machine next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_cur_dir;
    w_duty_nxt  = r_duty;
    w_dead_nxt  = r_dead_cnt;

    case (r_state)
      S_STOPPED: begin
        w_duty_nxt = '0;
        if (w_dir_cmd) begin
          w_state_nxt = S_DRIVE;
          w_dir_nxt   = r_p_cmd;
        end
      end

      S_DRIVE: begin
        if (r_p_cmd != r_cur_dir) begin
          w_state_nxt = S_BRAKE;
        end else if (w_tick) begin
          w_duty_nxt = w_slew;
        end
      end

      S_BRAKE: begin
        // Same direction requested again: resume without a dead-time dwell.
        if (r_p_cmd == r_cur_dir) begin
          w_state_nxt = S_DRIVE;
        end else if (r_duty == '0) begin
          w_state_nxt = S_DEAD;
          w_dead_nxt  = C_DEAD;
        end else if (w_tick) begin
          w_duty_nxt = w_brake;
        end
      end

      S_DEAD: begin
        w_duty_nxt = '0;
        if (r_dead_cnt == '0) begin
          w_state_nxt = S_STOPPED;
        end else if (w_tick) begin
          w_dead_nxt = r_dead_cnt - 32'd1;
        end
      end

      default: begin
        w_state_nxt = S_STOPPED;
        w_duty_nxt  = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    w_motor_nxt    = C_CMD_STOP;
    w_busy_nxt     = 1'b0;
    w_at_speed_nxt = 1'b0;
    if ((w_state_nxt == S_DRIVE) || (w_state_nxt == S_BRAKE)) begin
      w_motor_nxt = w_dir_nxt;
    end
    if ((w_state_nxt == S_BRAKE) || (w_state_nxt == S_DEAD)) begin
      w_busy_nxt = 1'b1;
    end
    if ((w_state_nxt == S_DRIVE) && (w_duty_nxt == r_p_tgt)) begin
      w_at_speed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_STOPPED;
      r_cur_dir   <= C_CMD_STOP;
      r_duty      <= '0;
      r_dead_cnt  <= '0;
      r_motor_out <= C_CMD_STOP;
      r_busy      <= 1'b0;
      r_at_speed  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_dir   <= w_dir_nxt;
      r_duty      <= w_duty_nxt;
      r_dead_cnt  <= w_dead_nxt;
      r_motor_out <= w_motor_nxt;
      r_busy      <= w_busy_nxt;
      r_at_speed  <= w_at_speed_nxt;
    end
  end

  assign bus.motor_out  = r_motor_out;
  assign bus.period     = C_PERIOD;
  assign bus.duty_cycle = r_duty;
  assign bus.busy       = r_busy;
  assign bus.at_speed   = r_at_speed;

endmodule
`default_nettype wire

// File: tb/tb_motion_ramp_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_motion_ramp_controller                                                  |
// | Scoreboard bench: model predicts the sequence of (motor_out, duty) states. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_motion_ramp_controller;

  localparam int PERIOD     = 1000;
  localparam int TICK_DIV   = 4;
  localparam int STEP       = 100;
  localparam int DEAD_TICKS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  motion_ramp_controller_if bus();

  motion_ramp_controller #(
    .PERIOD     (PERIOD),
    .TICK_DIV   (TICK_DIV),
    .STEP       (STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mo;
    logic [31:0] duty;
  } ev_t;

  ev_t         exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          mon_en      = 1'b0;
  logic [2:0]  prev_mo;
  logic [31:0] prev_duty;
  int          edge_cnt;

  // Reference model: direction currently driven (4 = stopped) and duty.
  int m_dir;
  int m_duty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Monitor: every visible change of (motor_out, duty) must be the next
  // predicted event, and duty may only move on ramp-tick edges.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && (bus.motor_out !== prev_mo || bus.duty_cycle !== prev_duty)) begin
        if (bus.duty_cycle !== prev_duty) begin
          vectors++;
          if (edge_cnt % TICK_DIV != 0) begin
            miscompares++;
            $display("FAIL tick_align: duty moved to %0d at edge %0d, required an edge multiple of %0d",
                     bus.duty_cycle, edge_cnt, TICK_DIV);
          end
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL event: got motor_out=%0d duty=%0d, required no change (out=%0d duty=%0d)",
                   bus.motor_out, bus.duty_cycle, prev_mo, prev_duty);
        end else begin
          e = exp_q.pop_front();
          if (e.mo !== bus.motor_out || e.duty !== bus.duty_cycle) begin
            miscompares++;
            $display("FAIL event: got motor_out=%0d duty=%0d, required motor_out=%0d duty=%0d",
                     bus.motor_out, bus.duty_cycle, e.mo, e.duty);
          end
        end
        prev_mo   = bus.motor_out;
        prev_duty = bus.duty_cycle;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic push(input int mo, input int d);
    ev_t e;
    e.mo   = 3'(mo);
    e.duty = 32'(d);
    exp_q.push_back(e);
  endtask

  // Predicts the whole visible trajectory a command produces from a settled state.
  task automatic model_cmd(input int c, input longint t);
    int cc;
    int tt;
    cc = (c > 4) ? 4 : c;
    tt = (t > PERIOD) ? PERIOD : int'(t);
    if (m_dir != 4 && cc != m_dir) begin
      while (m_duty > 0) begin
        m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
        push(m_dir, m_duty);
      end
      m_dir = 4;
      push(4, 0);
    end
    if (m_dir == 4 && cc != 4) begin
      m_dir = cc;
      push(cc, 0);
    end
    if (m_dir != 4) begin
      while (m_duty != tt) begin
        if (m_duty < tt) m_duty = (m_duty + STEP > tt) ? tt : m_duty + STEP;
        else             m_duty = (m_duty - STEP < tt) ? tt : m_duty - STEP;
        push(m_dir, m_duty);
      end
    end
  endtask

  // Caller is positioned at a negedge; strobe is held for exactly one cycle.
  task automatic send(input int c, input logic [31:0] t);
    bus.cmd         = 3'(c);
    bus.target_duty = t;
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL settle_timeout: %0d events still pending, required 0", exp_q.size());
      finish_run();
    end
    repeat (4 * TICK_DIV) @(negedge clk);
    chk("settle_motor_out", 32'(bus.motor_out), 32'(m_dir));
    chk("settle_duty", bus.duty_cycle, 32'(m_duty));
    chk("settle_busy", 32'(bus.busy), 32'd0);
    chk("settle_at_speed", 32'(bus.at_speed), (m_dir != 4) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_duty(input int d, input string name);
    int n;
    n = 0;
    while (bus.duty_cycle !== 32'(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.duty_cycle, 32'(d));
  endtask

  task automatic run_cmd(input int c, input logic [31:0] t);
    model_cmd(c, longint'(t));
    send(c, t);
    settle();
  endtask

  initial begin
    logic [31:0] t;
    int          c;
    int          sel;

    bus.cmd         = 3'd0;
    bus.cmd_valid   = 1'b0;
    bus.target_duty = '0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("reset_motor_out", 32'(bus.motor_out), 32'd4);
    chk("reset_duty", bus.duty_cycle, 32'd0);
    chk("reset_period", bus.period, 32'd1000);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_at_speed", 32'(bus.at_speed), 32'd0);

    rst_n     = 1'b1;
    m_dir     = 4;
    m_duty    = 0;
    prev_mo   = 3'd4;
    prev_duty = '0;
    mon_en    = 1'b1;
    @(negedge clk);

    // Forward ramp, then a full reversal with a busy check mid-brake.
    run_cmd(0, 32'd350);
    model_cmd(3, 200);
    send(3, 32'd200);
    repeat (3) @(negedge clk);
    chk("reversal_busy", 32'(bus.busy), 32'd1);
    settle();
    chk("period_const", bus.period, 32'd1000);

    // Brake abort: back to forward 350, start reversing, recover at duty 150.
    run_cmd(0, 32'd350);
    push(0, 250);
    push(0, 150);
    send(3, 32'd200);
    wait_duty(150, "abort_reach_150");
    chk("abort_busy", 32'(bus.busy), 32'd1);
    push(0, 250);
    push(0, 350);
    send(0, 32'd350);
    m_dir  = 0;
    m_duty = 350;
    settle();

    // Clamp, then an out-of-range code acting as stop.
    run_cmd(0, 32'd5000);
    chk("clamp_duty", bus.duty_cycle, 32'd1000);
    run_cmd(6, 32'd123);

    // Target zero enters DRIVE already at speed.
    run_cmd(2, 32'd0);
    chk("zero_tgt_at_speed", 32'(bus.at_speed), 32'd1);

    // Randomized commands from settled states.
    for (int i = 0; i < 25; i++) begin
      c   = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      if (sel == 0)      t = 32'd0;
      else if (sel == 1) t = 32'hFFFF_FFFF;
      else if (sel == 2) t = 32'd1000;
      else               t = 32'($urandom_range(0, 1100));
      run_cmd(c, t);
    end

    // Asynchronous reset in the middle of a ramp.
    run_cmd(4, 32'd0);
    push(1, 0);
    push(1, 100);
    push(1, 200);
    send(1, 32'd600);
    wait_duty(200, "async_reach_200");
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_motor_out", 32'(bus.motor_out), 32'd4);
    chk("async_duty", bus.duty_cycle, 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_at_speed", 32'(bus.at_speed), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    m_dir     = 4;
    m_duty    = 0;
    prev_mo   = 3'd4;
    prev_duty = '0;
    mon_en    = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_motor_out", 32'(bus.motor_out), 32'd4);
    chk("post_reset_duty", bus.duty_cycle, 32'd0);
    run_cmd(2, 32'd300);

    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/motion_ramp_controller.md
# motion_ramp_controller

Command-conditioning stage directly upstream of `motor_driver`: turns raw navigation commands (direction code plus target duty) into the `motor_out` / `period` / `duty_cycle` inputs the driver consumes. It slews duty cycle toward the target at a fixed rate (soft start, soft stop). On any direction change it ramps to zero and holds a stop dead-time before reversing, so the H-bridge never sees an abrupt reversal at speed.

## Interface
- `PERIOD`, 1000: PWM period in clk cycles, driven constant on `period`.
- `TICK_DIV`, 1000: clk cycles per ramp tick (≥1).
- `STEP`, 10: duty change per ramp tick (≥1).
- `DEAD_TICKS`, 50: ramp ticks held in stop between brake and next motion.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd`  in  3  requested motion code: 0 forward, 1 turn left, 2 turn right, 3 backward, 4 stop; 5–7 are treated as 4.
- `cmd_valid`  in  1  one-cycle strobe; loads `cmd` and `target_duty` into the pending registers.
- `target_duty`  in  32  requested duty in clk cycles; clamped to `PERIOD`.
- `motor_out`  out  3  code to `motor_driver` (0–4 only).
- `period`  out  32  always `PERIOD`.
- `duty_cycle`  out  32  current slewed duty.
- `busy`  out  1  high in BRAKE or DEAD.
- `at_speed`  out  1  high in DRIVE when `duty_cycle` == clamped target.

## Operation
- Pending registers `p_cmd` / `p_tgt`. Each `cmd_valid` overwrites both; the latest command wins and there is no queue. Codes 5–7 are stored as 4. The target is stored as min(`target_duty`, `PERIOD`).
- Prescaler counts 0..`TICK_DIV`-1 and wraps, running freely from reset. `tick` is asserted on the cycle the count equals `TICK_DIV`-1.
- Register `cur_dir` holds the direction currently driven.
- FSM states: STOPPED, DRIVE, BRAKE, DEAD.
  - **STOPPED:** `motor_out`=4, duty 0. If `p_cmd` is 0–3, set `cur_dir`=`p_cmd` and go to DRIVE; `motor_out` takes the new direction on the same edge.
  - **DRIVE:** `motor_out`=`cur_dir`. If `p_cmd` ≠ `cur_dir`, go to BRAKE. Otherwise, on each tick, slew duty toward `p_tgt` by at most `STEP` (up or down, no overshoot).
  - **BRAKE:** `motor_out`=`cur_dir`. On each tick, duty = duty > `STEP` ? duty−`STEP` : 0.
    - If `p_cmd` == `cur_dir` again, return to DRIVE immediately with no dead time.
    - Otherwise, when duty reaches 0, go to DEAD and load `dead_cnt`=`DEAD_TICKS`.
  - **DEAD:** `motor_out`=4, duty 0. Decrement `dead_cnt` on each tick; go to STOPPED when it reaches 0. With `DEAD_TICKS`=0, leave DEAD on the next clk edge. Commands arriving in DEAD stay pending.
- Arithmetic:
  - duty+`STEP` is computed 33 bits wide, then compared with the target, so no wrap is possible.
  - duty never exceeds `PERIOD`.
  - A target lowered below the current duty in DRIVE slews down without changing state.
- Motion command with target 0: enters DRIVE with duty 0, and `at_speed`=1.

## Timing
- Reset (async assert, sync release): `motor_out`=4, `duty_cycle`=0, `period`=`PERIOD`, `busy`=0, `at_speed`=0. Internal reset values: `p_cmd`=4, `p_tgt`=0, prescaler 0, `dead_cnt` 0, state STOPPED.
- All outputs are registered.
- Command latency: `cmd_valid` in cycle k updates pending at the end of k; the state and `motor_out` change at the end of k+1 and are visible in cycle k+2.
- Duty changes only on tick edges. The first ramp step comes at the first tick after entering DRIVE, between 1 and `TICK_DIV` cycles later.
- `cmd_valid` coinciding with a state transition: the transition uses the old pending value; the new value acts on the following cycle.
- Reset asserted mid-ramp: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
Tests 2–5 use `PERIOD`=1000, `TICK_DIV`=4, `STEP`=100, `DEAD_TICKS`=2.
1. **Reset:** hold `rst_n`=0 → `motor_out`=4, `duty_cycle`=0, `period`=1000, `busy`=0.
2. **Forward ramp:** `cmd`=0, target 350 → `motor_out`=0 two cycles later; duty 100, 200, 300, 350 on successive ticks; then `at_speed`=1.
3. **Reversal:** from forward at 350, `cmd`=3, target 200 →
   - `busy`=1; duty 250, 150, 50, 0 with `motor_out` still 0;
   - `motor_out`=4 for 2 ticks;
   - then `motor_out`=3 and duty 100, 200.
4. **Brake abort:** during BRAKE at duty 150, re-issue `cmd`=0, target 350 → back to DRIVE; duty 250, 350; `motor_out` never 4.
5. **Clamp and invalid code:** target 5000 → duty saturates at 1000. Then `cmd`=6 → brake to 0, DEAD, STOPPED with `motor_out`=4.
6. **Async reset mid-ramp:** drop `rst_n` between clock edges at duty 200 → `motor_out`=4 and duty 0 before the next edge. After release, the block stays STOPPED until the next `cmd_valid`.
